edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored input channels (2..16).
REQ-002 SHALL have parameter CHW, default $clog2(NCH), width of the channel-index output.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sig  input  NCH  asynchronous level inputs, one per channel.
REQ-006 SHALL have port mode  input  2*NCH  per-channel detect mode: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 SHALL have port evt_valid  output  1  an event is presented.
REQ-008 SHALL have port evt_ch  output  CHW  index of the channel being presented.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the presented event.
REQ-010 SHALL have port pending  output  NCH  per-channel pending-event flags.
REQ-011 SHALL have port ovf  output  NCH  sticky per-channel overflow flags.
REQ-012 SHALL have port ovf_clr  input  NCH  write-1-to-clear pulses for ovf.

Function
REQ-013 SHALL register each sig bit through two flops, s1 then s2; detection uses s1 (new) against s2 (old).
REQ-014 SHALL raise a channel event when it is armed and mode matches: rise = s1&~s2, fall = ~s1&s2, both = s1^s2; mode 00 raises no events.
REQ-015 SHALL set pending[i] on the clock edge following the cycle in which the event is raised; a sig change before edge k makes pending[i] visible after edge k+2.
REQ-016 SHALL use a two-state FSM: IDLE and PRESENT.
REQ-017 In IDLE with any pending bit set, SHALL select a channel round-robin, searching from last_grant+1 upward with wrap, then register evt_ch and enter PRESENT on the same edge.
REQ-018 In PRESENT, SHALL drive evt_valid=1 and hold evt_ch stable until evt_ready=1.
REQ-019 On evt_valid&evt_ready, SHALL clear pending[evt_ch], set last_grant=evt_ch, and return to IDLE; peak throughput is one event per 2 cycles.
REQ-020 SHALL set pending (not clear it) when a new event on channel i coincides with acceptance of channel i.
REQ-021 SHALL set ovf[i] when an event on channel i occurs while pending[i]=1 and channel i is not being accepted that cycle; the event is otherwise merged.
REQ-022 SHALL give set priority over clear when ovf set and ovf_clr[i] coincide.
REQ-023 SHALL retain existing pending bits when mode changes to 00; a disabled channel is still granted if pending.
REQ-024 SHALL keep evt_valid=0 in IDLE; evt_ready in IDLE is ignored.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear s1, s2, pending, ovf, evt_valid, evt_ch (0), set last_grant to NCH-1 (first search starts at channel 0), and enter IDLE.
REQ-026 SHALL suppress event detection (disarm) for the first two clock edges after rst_n returns high, so a level already high at release produces no event.
REQ-027 SHALL abandon any presented, unaccepted event on reset; it is lost, not replayed.

Structure
REQ-028 SHALL place the mode encodings (MODE_OFF/RISE/FALL/BOTH) and the FSM state type in shared package edge_arb_pkg.
REQ-029 SHALL implement per-channel synchroniser, edge detection, and pending/ovf logic in sub-module edge_det_ch, instantiated NCH times; the round-robin selector and FSM stay in the top module.

Verification
REQ-030 Post-reset arming: sig[0]=1 held through reset, mode=01 -> pending stays 4'b0000 and evt_valid stays 0 for 10 cycles.
REQ-031 Single rising edge: mode[1:0]=01, sig[0] 0->1 before edge k, evt_ready=1 -> pending[0]=1 after k+2, evt_valid=1 and evt_ch=0 after k+3, pending[0]=0 after k+4.
REQ-032 Round-robin: channels 0..3 all pending, evt_ready=1 -> grants in order 0,1,2,3; re-pending 0 and 2 after 3 -> grants 0, then 2.
REQ-033 Backpressure: evt_ready=0 for 5 cycles with channel 2 presented -> evt_valid=1 and evt_ch=2 stable throughout; accepted on the first cycle with ready=1.
REQ-034 Overflow: two rising edges on channel 1 while it is not accepted -> ovf[1]=1; ovf_clr[1] pulse -> ovf[1]=0; same-cycle set and clear -> ovf[1]=1.
REQ-035 Both-edge mode and reset mid-PRESENT: mode=11, pulse sig[3] -> two events; rst_n=0 while evt_valid=1 -> evt_valid=0 and pending=0 after the next edge.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types for the edge-event arbiter: detect-mode encodings, FSM states
// and the per-channel edge match helper.
package edge_arb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Edges after reset release during which detection stays disarmed.
  localparam int unsigned ARM_EDGES = 2;

  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic       s_new,
                                    input logic       s_old);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = s_new & ~s_old;
      MODE_FALL: hit = ~s_new & s_old;
      MODE_BOTH: hit = s_new ^ s_old;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One monitored channel: two-flop synchroniser, mode-selected edge detect,
// registered event strobe, pending flag and sticky overflow flag.
module edge_det_ch
  import edge_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sig,
  input  logic [1:0] i_mode,
  input  logic       i_armed,
  input  logic       i_accept,
  input  logic       i_ovf_clr,
  output logic       o_pending,
  output logic       o_ovf
);

  logic r_s1;
  logic r_s2;
  logic r_evt;
  logic r_pending;
  logic r_ovf;
  logic w_hit;
  logic w_ovf_set;

  assign w_hit     = i_armed & edge_hit(i_mode, r_s1, r_s2);
  // An event landing on an already-pending channel is merged; flag it unless
  // the existing one is being consumed on the same edge.
  assign w_ovf_set = r_evt & r_pending & ~i_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_evt     <= 1'b0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_s1      <= i_sig;
      r_s2      <= r_s1;
      r_evt     <= w_hit;
      r_pending <= r_evt | (r_pending & ~i_accept);
      r_ovf     <= w_ovf_set | (r_ovf & ~i_ovf_clr);
    end
  end

  assign o_pending = r_pending;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: NCH edge-detect channels feeding a round-robin
// selector and a two-state present/accept handshake FSM.
//   state      | meaning
//   ST_IDLE    | nothing presented; grant the next pending channel if any
//   ST_PRESENT | evt_valid high, evt_ch held until evt_ready
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   sig,
  input  logic [2*NCH-1:0] mode,
  output logic             evt_valid,
  output logic [CHW-1:0]   evt_ch,
  input  logic             evt_ready,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   ovf,
  input  logic [NCH-1:0]   ovf_clr
);

  state_e         r_state;
  state_e         w_state_next;
  logic [CHW-1:0] r_evt_ch;
  logic [CHW-1:0] r_last_grant;
  logic [CHW-1:0] w_sel_ch;
  logic [CHW-1:0] w_idx;
  logic           w_sel_found;
  logic           w_accept;
  logic           w_armed;
  logic [1:0]     r_arm_cnt;
  logic [NCH-1:0] w_pending;
  logic [NCH-1:0] w_ovf;
  logic [NCH-1:0] w_accept_vec;

  // Saturating count of edges since reset release; detection opens once it
  // reaches ARM_EDGES so levels already high at release are not seen as edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arm_cnt <= 2'd0;
    end else if (r_arm_cnt != 2'(ARM_EDGES)) begin
      r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  assign w_armed  = (r_arm_cnt == 2'(ARM_EDGES));
  assign w_accept = (r_state == ST_PRESENT) & evt_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_accept_vec[g] = w_accept & (r_evt_ch == CHW'(g));

    edge_det_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sig     (sig[g]),
      .i_mode    (mode[2*g +: 2]),
      .i_armed   (w_armed),
      .i_accept  (w_accept_vec[g]),
      .i_ovf_clr (ovf_clr[g]),
      .o_pending (w_pending[g]),
      .o_ovf     (w_ovf[g])
    );
  end

  // Round-robin: first pending channel at last_grant+1, +2, ... with wrap.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_ch    = '0;
    w_idx       = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = CHW'((int'(r_last_grant) + k) % NCH);
      if (!w_sel_found && w_pending[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel_ch    = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_sel_found) w_state_next = ST_PRESENT;
      ST_PRESENT: if (evt_ready)   w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_evt_ch     <= '0;
      r_last_grant <= CHW'(NCH - 1);
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_sel_found) begin
        r_evt_ch <= w_sel_ch;
      end
      if (w_accept) begin
        r_last_grant <= r_evt_ch;
      end
    end
  end

  assign evt_valid = (r_state == ST_PRESENT);
  assign evt_ch    = r_evt_ch;
  assign pending   = w_pending;
  assign ovf       = w_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NCH=4); expected grants are queued
// as edges are driven and checked as the DUT hands events over.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig;
  logic [7:0] mode;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  int q[$];

  always #5 clk = ~clk;

  edge_event_arbiter #(.NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig       (sig),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; outputs are read at that point.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int  n;
    logic done;
    n = 0;
    done = (q.size() == 0) && (evt_valid === 1'b0) && (pending === 4'b0000);
    while (!done && n < budget) begin
      cycle();
      n++;
      done = (q.size() == 0) && (evt_valid === 1'b0) && (pending === 4'b0000);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected grant.
  always @(negedge clk) begin
    int exp_ch;
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL grant_unexpected: observed ch %0d, expected no grant", evt_ch);
      end else begin
        exp_ch = q.pop_front();
        chk("grant_ch", 32'(evt_ch), 32'(exp_ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    sig       = 4'b0001;
    mode      = 8'b00_00_00_01;
    evt_ready = 1'b0;
    ovf_clr   = 4'b0000;
    cycle(3);
    chk("rst_valid",   32'(evt_valid), 32'd0);
    chk("rst_pending", 32'(pending),   32'h0);
    chk("rst_ovf",     32'(ovf),       32'h0);
    chk("rst_ch",      32'(evt_ch),    32'h0);

    // Level high through reset must not become an event.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("arm_pending", 32'(pending),   32'h0);
      chk("arm_valid",   32'(evt_valid), 32'd0);
    end

    // Single rising edge on channel 0, latency check.
    sig = 4'b0000;
    cycle(3);
    evt_ready = 1'b1;
    sig = 4'b0001;
    q.push_back(0);
    cycle();
    chk("lat_k_pending",  32'(pending), 32'h0);
    cycle();
    chk("lat_k1_pending", 32'(pending), 32'h0);
    cycle();
    chk("lat_k2_pending", 32'(pending),   32'h1);
    chk("lat_k2_valid",   32'(evt_valid), 32'd0);
    cycle();
    chk("lat_k3_valid",   32'(evt_valid), 32'd1);
    chk("lat_k3_ch",      32'(evt_ch),    32'd0);
    cycle();
    chk("lat_k4_pending", 32'(pending),   32'h0);
    chk("lat_k4_valid",   32'(evt_valid), 32'd0);

    // Round-robin from a fresh reset (first search starts at channel 0).
    evt_ready = 1'b0;
    rst_n = 1'b0;
    sig   = 4'b0000;
    mode  = 8'b01_01_01_01;
    cycle(2);
    rst_n = 1'b1;
    cycle(4);
    sig = 4'b1111;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3);
    cycle(3);
    chk("rr_all_pending", 32'(pending),   32'hF);
    chk("rr_idle_valid",  32'(evt_valid), 32'd0);
    cycle();
    chk("rr_first_valid", 32'(evt_valid), 32'd1);
    chk("rr_first_ch",    32'(evt_ch),    32'd0);
    evt_ready = 1'b1;
    drain("rr_drain_0123", 30);

    sig = 4'b1010;
    cycle(3);
    sig = 4'b1111;
    q.push_back(0); q.push_back(2);
    drain("rr_drain_02", 30);

    // last_grant is now 2, so channel 3 must beat channel 0.
    sig = 4'b0110;
    cycle(3);
    sig = 4'b1111;
    q.push_back(3); q.push_back(0);
    drain("rr_drain_30", 30);

    // Backpressure on channel 2.
    evt_ready = 1'b0;
    sig = 4'b1011;
    cycle(3);
    sig = 4'b1111;
    q.push_back(2);
    wait_valid("bp_present", 10);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_valid", 32'(evt_valid), 32'd1);
      chk("bp_hold_ch",    32'(evt_ch),    32'd2);
    end
    evt_ready = 1'b1;
    cycle();
    chk("bp_accept_valid",   32'(evt_valid), 32'd0);
    chk("bp_accept_pending", 32'(pending),   32'h0);
    chk("bp_queue_empty",    32'(q.size()),  32'd0);

    // Overflow on channel 1.
    evt_ready = 1'b0;
    sig = 4'b1101;
    cycle(3);
    sig = 4'b1111;
    q.push_back(1);
    cycle(3);
    chk("ovf_first_pending", 32'(pending), 32'h2);
    chk("ovf_first_none",    32'(ovf),     32'h0);
    sig = 4'b1101;
    cycle(2);
    sig = 4'b1111;
    cycle(3);
    chk("ovf_set", 32'(ovf), 32'h2);
    ovf_clr = 4'b0010;
    cycle();
    ovf_clr = 4'b0000;
    chk("ovf_clr", 32'(ovf), 32'h0);
    sig = 4'b1101;
    cycle(3);
    sig = 4'b1111;
    cycle(2);
    ovf_clr = 4'b0010;
    cycle();
    ovf_clr = 4'b0000;
    chk("ovf_set_beats_clr", 32'(ovf), 32'h2);
    ovf_clr = 4'b0010;
    cycle();
    ovf_clr = 4'b0000;
    chk("ovf_clr_again", 32'(ovf), 32'h0);
    evt_ready = 1'b1;
    drain("ovf_drain", 20);

    // Both-edge mode on channel 3: a pulse yields two events.
    mode = 8'b11_01_01_01;
    cycle();
    sig = 4'b0111;
    q.push_back(3);
    cycle(4);
    sig = 4'b1111;
    q.push_back(3);
    drain("both_drain", 30);
    chk("both_no_ovf", 32'(ovf), 32'h0);

    // Reset while an event is presented: it is dropped, never replayed.
    evt_ready = 1'b0;
    sig = 4'b0111;
    wait_valid("rstp_present", 10);
    chk("rstp_ch", 32'(evt_ch), 32'd3);
    rst_n = 1'b0;
    cycle();
    chk("rstp_valid",   32'(evt_valid), 32'd0);
    chk("rstp_pending", 32'(pending),   32'h0);
    chk("rstp_ch_zero", 32'(evt_ch),    32'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cycle(10);
    chk("rstp_no_replay_pending", 32'(pending),   32'h0);
    chk("rstp_no_replay_valid",   32'(evt_valid), 32'd0);

    // Disabling a channel keeps its pending event, which is still granted.
    evt_ready = 1'b0;
    sig = 4'b0110;
    cycle(3);
    sig = 4'b0111;
    q.push_back(0);
    cycle(3);
    chk("off_pending_before", 32'(pending), 32'h1);
    mode = 8'b11_01_01_00;
    cycle(2);
    chk("off_pending_kept", 32'(pending),   32'h1);
    chk("off_valid",        32'(evt_valid), 32'd1);
    chk("off_ch",           32'(evt_ch),    32'd0);
    evt_ready = 1'b1;
    drain("off_drain", 20);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
